fpga_top: RTL and testbench

Board-level top of the add/jump-up teaching processor. It has a 16-entry instruction memory, four 16-bit registers and a 4-bit program counter. In program mode, DIP switches and buttons write ADD / JUMP-UP instructions into memory. In run mode, it executes one instruction per clock and exposes the PC, operand bus and register file directly on board outputs.

---
 rtl/fpga_top.sv | 163 ++++++++++++++++
 tb/tb_fpga_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_top.sv
// fpga_top -- board-level top of the add/jump-up teaching processor.
//
// Holds a 16 x 20-bit instruction memory, four 16-bit registers and a 4-bit
// program counter. In program mode the DIP switches and buttons write
// instructions at pc. In run mode one instruction executes per clock.
//
// Instruction word: {op, dest[1:0], src, imm[15:0]}; op 0 = ADD, op 1 = JUMP-UP.
//
// Ports:
//   btn_adv       in   1   system clock, rising edge
//   rst           in   1   synchronous active-high reset, highest priority
//   dip_value_in  in  16   immediate value / jump offset
//   btn_add       in   1   program mode: write ADD word (wins over btn_jump)
//   btn_jump      in   1   program mode: write JUMP-UP word
//   btn_dest_msb  in   1   dest[1] of the word being written
//   dip_ctrl      in   3   [2]=prog, [1]=src, [0]=dest[0]
//   pc            out  4   program counter / write pointer
//   o_b           out 16   registered operand bus
//   o_r0..o_r3    out 16   register file contents
module fpga_top (
  input  logic        btn_adv,
  input  logic        rst,
  input  logic [15:0] dip_value_in,
  input  logic        btn_add,
  input  logic        btn_jump,
  input  logic        btn_dest_msb,
  input  logic [2:0]  dip_ctrl,
  output logic [3:0]  pc,
  output logic [15:0] o_b,
  output logic [15:0] o_r0,
  output logic [15:0] o_r1,
  output logic [15:0] o_r2,
  output logic [15:0] o_r3
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_PROG = 2'd1,
    MODE_EXIT = 2'd2
  } mode_e;

  // Architectural state.
  logic [19:0] mem_r [16];
  logic [15:0] regs_r [4];
  logic [3:0]  pc_r;
  logic [15:0] o_b_r;
  logic        prev_prog_r;

  // Decode / next-state signals.
  mode_e       mode_s;
  logic [19:0] instr_s;
  logic        op_s;
  logic [1:0]  dest_s;
  logic        src_s;
  logic [15:0] imm_s;
  logic [15:0] operand_s;
  logic [3:0]  pc_nxt_s;
  logic [15:0] o_b_nxt_s;
  logic        mem_we_s;
  logic [19:0] mem_wdata_s;
  logic        reg_we_s;
  logic [15:0] reg_wdata_s;

  // Mode select: the cycle after prog drops is a dedicated pc-clear cycle.
  always_comb begin
    mode_s = MODE_RUN;
    if (dip_ctrl[2]) begin
      mode_s = MODE_PROG;
    end else if (prev_prog_r) begin
      mode_s = MODE_EXIT;
    end else begin
      mode_s = MODE_RUN;
    end
  end

  // Combinational fetch and decode of mem[pc]; operand B uses pre-edge registers.
  always_comb begin
    instr_s = mem_r[pc_r];
    op_s    = instr_s[19];
    dest_s  = instr_s[18:17];
    src_s   = instr_s[16];
    imm_s   = instr_s[15:0];
    if (src_s) begin
      operand_s = regs_r[imm_s[1:0]];
    end else begin
      operand_s = imm_s;
    end
  end

  // Next-state logic for pc, operand bus, memory write and register write.
  always_comb begin
    pc_nxt_s    = pc_r;
    o_b_nxt_s   = o_b_r;
    mem_we_s    = 1'b0;
    mem_wdata_s = 20'h00000;
    reg_we_s    = 1'b0;
    reg_wdata_s = 16'h0000;
    case (mode_s)
      MODE_PROG: begin
        o_b_nxt_s = dip_value_in;
        if (btn_add || btn_jump) begin
          // ADD has priority: op is 1 only when jump is pressed alone.
          mem_we_s    = 1'b1;
          mem_wdata_s = {~btn_add, btn_dest_msb, dip_ctrl[0], dip_ctrl[1], dip_value_in};
          pc_nxt_s    = pc_r + 4'd1;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      MODE_EXIT: begin
        pc_nxt_s = 4'd0;
      end
      MODE_RUN: begin
        if (op_s == 1'b0) begin
          reg_we_s    = 1'b1;
          reg_wdata_s = regs_r[dest_s] + operand_s;
          o_b_nxt_s   = operand_s;
          pc_nxt_s    = pc_r + 4'd1;
        end else begin
          // Offset 0 leaves pc unchanged, which acts as a halt.
          pc_nxt_s  = pc_r - imm_s[3:0];
          o_b_nxt_s = {12'h000, imm_s[3:0]};
        end
      end
      default: begin
        pc_nxt_s = pc_r;
      end
    endcase
  end

  // State registers; reset clears memory as well as the datapath.
  always_ff @(posedge btn_adv) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 20'h00000;
      end
      for (int j = 0; j < 4; j++) begin
        regs_r[j] <= 16'h0000;
      end
      pc_r        <= 4'd0;
      o_b_r       <= 16'h0000;
      prev_prog_r <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      o_b_r       <= o_b_nxt_s;
      prev_prog_r <= dip_ctrl[2];
      if (mem_we_s) begin
        mem_r[pc_r] <= mem_wdata_s;
      end
      if (reg_we_s) begin
        regs_r[dest_s] <= reg_wdata_s;
      end
    end
  end

  assign pc   = pc_r;
  assign o_b  = o_b_r;
  assign o_r0 = regs_r[0];
  assign o_r1 = regs_r[1];
  assign o_r2 = regs_r[2];
  assign o_r3 = regs_r[3];

endmodule

// File: tb/tb_fpga_top.sv
// Testbench for fpga_top: directed scenarios plus randomized stimulus, all
// compared every cycle against a behavioural model of the processor.
module tb_fpga_top;

  logic        btn_adv;
  logic        rst;
  logic [15:0] dip_value_in;
  logic        btn_add;
  logic        btn_jump;
  logic        btn_dest_msb;
  logic [2:0]  dip_ctrl;
  logic [3:0]  pc;
  logic [15:0] o_b;
  logic [15:0] o_r0;
  logic [15:0] o_r1;
  logic [15:0] o_r2;
  logic [15:0] o_r3;

  int checks;
  int failures;

  // Reference model state.
  int m_mem [16];
  int m_r [4];
  int m_pc;
  int m_ob;
  int m_prev;

  fpga_top dut (
    .btn_adv      (btn_adv),
    .rst          (rst),
    .dip_value_in (dip_value_in),
    .btn_add      (btn_add),
    .btn_jump     (btn_jump),
    .btn_dest_msb (btn_dest_msb),
    .dip_ctrl     (dip_ctrl),
    .pc           (pc),
    .o_b          (o_b),
    .o_r0         (o_r0),
    .o_r1         (o_r1),
    .o_r2         (o_r2),
    .o_r3         (o_r3)
  );

  initial btn_adv = 1'b0;
  always #5 btn_adv = ~btn_adv;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock of the processor rules to the model using current inputs.
  task automatic model_step();
    int w, op, d, s, imm, b;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_pc = 0; m_ob = 0; m_prev = 0;
    end else begin
      if (dip_ctrl[2]) begin
        m_ob = dip_value_in;
        if (btn_add || btn_jump) begin
          op = btn_add ? 0 : 1;
          d  = btn_dest_msb * 2 + dip_ctrl[0];
          m_mem[m_pc] = op * 524288 + d * 131072 + dip_ctrl[1] * 65536 + dip_value_in;
          m_pc = (m_pc + 1) % 16;
        end
      end else if (m_prev != 0) begin
        m_pc = 0;
      end else begin
        w   = m_mem[m_pc];
        op  = w / 524288;
        d   = (w / 131072) % 4;
        s   = (w / 65536) % 2;
        imm = w % 65536;
        if (op == 0) begin
          b = s ? m_r[imm % 4] : imm;
          m_r[d] = (m_r[d] + b) % 65536;
          m_ob = b;
          m_pc = (m_pc + 1) % 16;
        end else begin
          m_pc = (m_pc - (imm % 16) + 16) % 16;
          m_ob = imm % 16;
        end
      end
      m_prev = dip_ctrl[2];
    end
  endtask

  // One clock: advance model, wait for edge, sample 1 time unit later.
  task automatic step();
    model_step();
    @(posedge btn_adv);
    #1;
    check_val("pc", int'(pc), m_pc);
    check_val("o_b", int'(o_b), m_ob);
    check_val("r0", int'(o_r0), m_r[0]);
    check_val("r1", int'(o_r1), m_r[1]);
    check_val("r2", int'(o_r2), m_r[2]);
    check_val("r3", int'(o_r3), m_r[3]);
  endtask

  task automatic idle_inputs(input logic prog);
    rst = 1'b0; btn_add = 1'b0; btn_jump = 1'b0; btn_dest_msb = 1'b0;
    dip_value_in = 16'h0000; dip_ctrl = {prog, 2'b00};
  endtask

  task automatic do_reset(input int n);
    idle_inputs(1'b0);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  // Program one word: add/jump buttons, dest msb, src, dest lsb, value.
  task automatic prog_word(input logic add, input logic jmp, input logic dmsb,
                           input logic src, input logic dlsb, input logic [15:0] val);
    rst = 1'b0; btn_add = add; btn_jump = jmp; btn_dest_msb = dmsb;
    dip_ctrl = {1'b1, src, dlsb}; dip_value_in = val;
    step();
  endtask

  task automatic run_cycles(input int n);
    idle_inputs(1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0; m_ob = 0; m_prev = 0;
    idle_inputs(1'b0);

    // Reset state.
    do_reset(2);
    check_val("rst_pc", int'(pc), 0);
    check_val("rst_ob", int'(o_b), 0);
    check_val("rst_r0", int'(o_r0), 0);

    // Three ADDs, then run.
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd10);
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20);
    check_val("prog_pc", int'(pc), 3);
    check_val("prog_echo", int'(o_b), 20);
    run_cycles(4);
    check_val("add3_r0", int'(o_r0), 15);
    check_val("add3_r1", int'(o_r1), 20);
    check_val("add3_pc", int'(pc), 3);
    check_val("add3_ob", int'(o_b), 20);
    run_cycles(13);
    check_val("wrap_pc", int'(pc), 0);
    run_cycles(2);
    check_val("wrap_r0", int'(o_r0), 30);

    // Loop: ADD R2 imm 1 ; JUMP-UP 1.
    do_reset(1);
    prog_word(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    prog_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    run_cycles(1);
    for (int k = 1; k <= 3; k++) begin
      run_cycles(1);
      check_val("loop_pc1", int'(pc), 1);
      check_val("loop_r2", int'(o_r2), k);
      run_cycles(1);
      check_val("loop_pc0", int'(pc), 0);
      check_val("loop_ob", int'(o_b), 1);
    end

    // Halt: JUMP-UP 0 at pc 0.
    do_reset(1);
    prog_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    run_cycles(11);
    check_val("halt_pc", int'(pc), 0);
    check_val("halt_r0", int'(o_r0), 0);

    // Register source and 16-bit wrap.
    do_reset(1);
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
    prog_word(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    prog_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    run_cycles(3);
    check_val("srcreg_r0", int'(o_r0), 14);
    check_val("srcreg_ob", int'(o_b), 7);
    run_cycles(2);
    check_val("wrap16_r1", int'(o_r1), 1);

    // Both buttons: one ADD word, pc +1.
    do_reset(1);
    prog_word(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    check_val("both_pc", int'(pc), 1);
    run_cycles(2);
    check_val("both_r0", int'(o_r0), 3);
    check_val("both_pc_run", int'(pc), 1);

    // Reset mid-run.
    run_cycles(5);
    do_reset(1);
    check_val("midrst_pc", int'(pc), 0);
    check_val("midrst_r0", int'(o_r0), 0);
    run_cycles(3);
    check_val("midrst_mem_r0", int'(o_r0), 0);

    // Randomized mix of programming, running and occasional reset.
    begin
      logic prog;
      prog = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 24) == 0) prog = ~prog;
        btn_add      = ($urandom_range(0, 2) == 0);
        btn_jump     = ($urandom_range(0, 2) == 0);
        btn_dest_msb = $urandom_range(0, 1);
        dip_ctrl     = {prog, 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 1) == 0) dip_value_in = 16'($urandom_range(0, 15));
        else dip_value_in = 16'($urandom);
        rst = (!prog && $urandom_range(0, 199) == 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
